mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
Two-requester, round-robin arbiter that shares one 32-bit datapath built on the existing Mux2x1. Each requester presents data with a valid/ready handshake. The arbiter drives the Mux2x1 select, registers the chosen word, and presents it downstream with valid/ready. Optional per-requester lock gives atomic bursts. It sits in front of any shared single-port consumer, such as a write-back bus or memory port.

Parameters:
WIDTH, 32, data width of both inputs and the output (matches Mux2x1)
CNT_W, 16, width of the per-requester saturating grant counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in0_valid  input  1  requester 0 has a word
in0_data  input  WIDTH  requester 0 word
in0_lock  input  1  requester 0 holds the grant after this beat
in0_ready  output  1  requester 0 word accepted this cycle
in1_valid  input  1  requester 1 has a word
in1_data  input  WIDTH  requester 1 word
in1_lock  input  1  requester 1 holds the grant after this beat
in1_ready  output  1  requester 1 word accepted this cycle
out_valid  output  1  out_data holds a word
out_data  output  WIDTH  registered arbitration winner
out_src  output  1  index of the requester that produced out_data
out_ready  input  1  downstream accepts out_data
grant_cnt0  output  CNT_W  saturating count of beats accepted from requester 0
grant_cnt1  output  CNT_W  saturating count of beats accepted from requester 1

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_src=0, grant_cnt0/1=0, state=ARB, last_grant=1 (requester 0 wins the first tie).
- Can-accept condition: can_accept = !out_valid || out_ready. Only one requester is accepted per cycle.
- Ready signals are combinational: inN_ready = can_accept && inN_valid && (sel==N) && !reset. A requester must hold valid and data stable until it sees ready.
- sel (the Mux2x1 select) is chosen by state:
  - ARB, only one valid: sel is that requester.
  - ARB, both valid: sel = !last_grant.
  - ARB, none valid: sel = last_grant; no accept.
  - LOCK0: sel=0. Requester 1 is never accepted, even if requester 0 is idle.
  - LOCK1: sel=1, symmetric.
- On accept (rising clk): out_data <= Mux2x1 output, out_src <= sel, out_valid <= 1, last_grant <= sel, accepted requester's grant_cnt += 1, saturating at all-ones.
- No accept but out_valid && out_ready: out_valid <= 0 and out_data holds its value.
- Latency and throughput: one cycle from accept to out_valid. Back-to-back accepts sustain one word per cycle while out_ready=1.
- State transitions (evaluated only on an accepted beat; otherwise the state holds):
  - ARB -> LOCKn if the accepted beat from requester n has inN_lock=1.
  - LOCKn -> LOCKn while accepted beats carry lock=1.
  - LOCKn -> ARB on an accepted beat with lock=0.
- Stall: out_valid=1 and out_ready=0 gives no ready to either requester. out_data, out_src and the state all hold.
- Reset mid-burst or mid-stall: the next cycle returns to ARB with out_valid=0. A pending word is dropped, and no ready is asserted in the reset cycle.
- Simultaneous output drain and new accept in one cycle: out_valid stays 1 and out_data takes the new word.

Decomposition:
- Shared package arb_pkg holds:
  - the state typedef enum {ARB, LOCK0, LOCK1}
  - localparam REQ0=1'b0, REQ1=1'b1
  - the default WIDTH=32
- The datapath is one instance of the existing Mux2x1 (ports i0, i1, sel, out), with i0=in0_data, i1=in1_data.
- Arbitration FSM, output register and counters stay in this module. No further sub-module.

Test Plan:
- Reset, then in0_valid=1, in0_data=32'h12345678, out_ready=1 -> in0_ready=1 in that cycle; next cycle out_valid=1, out_data=32'h12345678, out_src=0, grant_cnt0=1.
- Both valid every cycle, in0_data=32'h12345678, in1_data=32'h87654321, out_ready=1, 4 cycles -> outputs alternate 12345678, 87654321, 12345678, 87654321; grant_cnt0=grant_cnt1=2.
- Requester 1 sends 3 beats with in1_lock=1,1,0 while in0_valid=1 throughout -> three consecutive outputs with out_src=1, then out_src=0; in0_ready stays 0 during the lock.
- Hold out_ready=0 for 5 cycles with out_valid=1 -> in0_ready=in1_ready=0; out_data is unchanged; counters are unchanged; on out_ready=1 the word drains and the next word is accepted in the same cycle.
- Assert reset for 1 cycle in the middle of a LOCK0 burst with out_valid=1 -> next cycle out_valid=0, counters are 0, and a tie then goes to requester 0.
- Force grant_cnt0 to saturate (CNT_W=4 build, 20 beats from requester 0) -> grant_cnt0 stays at 4'hF.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Requester/downstream handshake bundle for mux2_rr_arbiter.
interface mux2_rr_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             in0_valid;
   logic [WIDTH-1:0] in0_data;
   logic             in0_lock;
   logic             in0_ready;
   logic             in1_valid;
   logic [WIDTH-1:0] in1_data;
   logic             in1_lock;
   logic             in1_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_src;
   logic             out_ready;
   logic [CNT_W-1:0] grant_cnt0;
   logic [CNT_W-1:0] grant_cnt1;

   modport master (
      output in0_valid, in0_data, in0_lock,
      output in1_valid, in1_data, in1_lock,
      output out_ready,
      input  in0_ready, in1_ready,
      input  out_valid, out_data, out_src,
      input  grant_cnt0, grant_cnt1
   );

   modport slave (
      input  in0_valid, in0_data, in0_lock,
      input  in1_valid, in1_data, in1_lock,
      input  out_ready,
      output in0_ready, in1_ready,
      output out_valid, out_data, out_src,
      output grant_cnt0, grant_cnt1
   );
endinterface

// File: rtl/Mux2x1.sv
// Plain two-input word multiplexer shared by both requesters.
module Mux2x1 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);
   assign out = sel ? i1 : i0;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter with per-requester lock, registered output and grant counters.
//   state | meaning
//   ARB   | round-robin between valid requesters, last_grant breaks ties
//   LOCK0 | requester 0 owns the datapath until it sends a beat with lock=0
//   LOCK1 | requester 1 owns the datapath until it sends a beat with lock=0
module mux2_rr_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              reset,
   mux2_rr_arbiter_if.slave bus
);

   localparam logic [1:0] ST_ARB   = 2'(ARB);
   localparam logic [1:0] ST_LOCK0 = 2'(LOCK0);
   localparam logic [1:0] ST_LOCK1 = 2'(LOCK1);

   logic [1:0]       state_q, state_d;
   logic             last_grant_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_src_q;
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   logic             sel;
   logic             sel_valid;
   logic             sel_lock;
   logic             can_accept;
   logic             accept;
   logic [WIDTH-1:0] mux_out;

   Mux2x1 #(.WIDTH(WIDTH)) u_mux (
      .i0  (bus.in0_data),
      .i1  (bus.in1_data),
      .sel (sel),
      .out (mux_out)
   );

   always_comb begin
      sel = last_grant_q;
      case (state_q)
         ST_LOCK0: sel = REQ0;
         ST_LOCK1: sel = REQ1;
         default: begin
            if (bus.in0_valid && !bus.in1_valid)
               sel = REQ0;
            else if (bus.in1_valid && !bus.in0_valid)
               sel = REQ1;
            else if (bus.in0_valid && bus.in1_valid)
               sel = !last_grant_q;
            else
               sel = last_grant_q;
         end
      endcase
   end

   assign sel_valid  = (sel == REQ1) ? bus.in1_valid : bus.in0_valid;
   assign sel_lock   = (sel == REQ1) ? bus.in1_lock  : bus.in0_lock;
   assign can_accept = !out_valid_q || bus.out_ready;
   // Reset gates ready so nothing is consumed in a cycle whose result is discarded.
   assign accept     = can_accept && sel_valid && !reset;

   assign bus.in0_ready = accept && (sel == REQ0);
   assign bus.in1_ready = accept && (sel == REQ1);

   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (sel_lock)
            state_d = (sel == REQ1) ? ST_LOCK1 : ST_LOCK0;
         else
            state_d = ST_ARB;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ARB;
         last_grant_q <= REQ1;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= 1'b0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= mux_out;
            out_src_q    <= sel;
            last_grant_q <= sel;
            if (sel == REQ0) begin
               if (cnt0_q != {CNT_W{1'b1}})
                  cnt0_q <= cnt0_q + CNT_W'(1);
            end else begin
               if (cnt1_q != {CNT_W{1'b1}})
                  cnt1_q <= cnt1_q + CNT_W'(1);
            end
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_src    = out_src_q;
   assign bus.grant_cnt0 = cnt0_q;
   assign bus.grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_mux2_rr_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   mux2_rr_arbiter_if #(.WIDTH(32), .CNT_W(16)) bus_a ();
   mux2_rr_arbiter_if #(.WIDTH(32), .CNT_W(4))  bus_b ();

   mux2_rr_arbiter #(.WIDTH(32), .CNT_W(16)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
   mux2_rr_arbiter #(.WIDTH(32), .CNT_W(4))  dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

   int tests  = 0;
   int errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      bus_a.in0_valid = 1'b0; bus_a.in0_data = '0; bus_a.in0_lock = 1'b0;
      bus_a.in1_valid = 1'b0; bus_a.in1_data = '0; bus_a.in1_lock = 1'b0;
      bus_a.out_ready = 1'b1;
   endtask

   task automatic reset_a();
      idle_a();
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
   endtask

   task automatic test_reset();
      idle_a();
      rst_a = 1'b1;
      bus_a.in0_valid = 1'b1;
      bus_a.in1_valid = 1'b1;
      #1;
      tests++; if (bus_a.in0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b want 0", bus_a.in0_ready); end
      tests++; if (bus_a.in1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b want 0", bus_a.in1_ready); end
      tick();
      tests++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus_a.out_valid); end
      tests++; if (bus_a.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus_a.out_data); end
      tests++; if (bus_a.out_src !== 1'b0) begin errors++; $display("FAIL reset_out_src got %b want 0", bus_a.out_src); end
      tests++; if (bus_a.grant_cnt0 !== 16'h0) begin errors++; $display("FAIL reset_cnt0 got %0d want 0", bus_a.grant_cnt0); end
      tests++; if (bus_a.grant_cnt1 !== 16'h0) begin errors++; $display("FAIL reset_cnt1 got %0d want 0", bus_a.grant_cnt1); end
      rst_a = 1'b0;
      idle_a();
   endtask

   task automatic test_single();
      reset_a();
      bus_a.in0_valid = 1'b1;
      bus_a.in0_data  = 32'h12345678;
      #1;
      tests++; if (bus_a.in0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus_a.in0_ready); end
      tick();
      bus_a.in0_valid = 1'b0;
      tests++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", bus_a.out_valid); end
      tests++; if (bus_a.out_data !== 32'h12345678) begin errors++; $display("FAIL single_out_data got %h want 12345678", bus_a.out_data); end
      tests++; if (bus_a.out_src !== 1'b0) begin errors++; $display("FAIL single_out_src got %b want 0", bus_a.out_src); end
      tests++; if (bus_a.grant_cnt0 !== 16'd1) begin errors++; $display("FAIL single_cnt0 got %0d want 1", bus_a.grant_cnt0); end
   endtask

   task automatic test_alternate();
      logic [31:0] exp;
      reset_a();
      bus_a.in0_valid = 1'b1; bus_a.in0_data = 32'h12345678;
      bus_a.in1_valid = 1'b1; bus_a.in1_data = 32'h87654321;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (bus_a.in0_ready !== (i % 2 == 0)) begin errors++; $display("FAIL alt_ready0[%0d] got %b want %b", i, bus_a.in0_ready, (i % 2 == 0)); end
         tests++; if (bus_a.in1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL alt_ready1[%0d] got %b want %b", i, bus_a.in1_ready, (i % 2 == 1)); end
         tick();
         exp = (i % 2 == 0) ? 32'h12345678 : 32'h87654321;
         tests++; if (bus_a.out_data !== exp) begin errors++; $display("FAIL alt_data[%0d] got %h want %h", i, bus_a.out_data, exp); end
      end
      tests++; if (bus_a.grant_cnt0 !== 16'd2) begin errors++; $display("FAIL alt_cnt0 got %0d want 2", bus_a.grant_cnt0); end
      tests++; if (bus_a.grant_cnt1 !== 16'd2) begin errors++; $display("FAIL alt_cnt1 got %0d want 2", bus_a.grant_cnt1); end
      idle_a();
   endtask

   task automatic test_lock();
      reset_a();
      bus_a.in0_valid = 1'b1; bus_a.in0_data = 32'hA0A0A0A0; bus_a.in0_lock = 1'b0;
      bus_a.in1_valid = 1'b1; bus_a.in1_data = 32'h87654321; bus_a.in1_lock = 1'b1;
      #1;
      tests++; if (bus_a.in0_ready !== 1'b1) begin errors++; $display("FAIL lock_pre_ready0 got %b want 1", bus_a.in0_ready); end
      tick();
      for (int i = 0; i < 3; i++) begin
         bus_a.in1_data = 32'h87654321 + 32'(i);
         bus_a.in1_lock = (i < 2);
         #1;
         tests++; if (bus_a.in1_ready !== 1'b1) begin errors++; $display("FAIL lock_ready1[%0d] got %b want 1", i, bus_a.in1_ready); end
         tests++; if (bus_a.in0_ready !== 1'b0) begin errors++; $display("FAIL lock_ready0[%0d] got %b want 0", i, bus_a.in0_ready); end
         tick();
         tests++; if (bus_a.out_src !== 1'b1) begin errors++; $display("FAIL lock_src[%0d] got %b want 1", i, bus_a.out_src); end
         tests++; if (bus_a.out_data !== 32'h87654321 + 32'(i)) begin errors++; $display("FAIL lock_data[%0d] got %h want %h", i, bus_a.out_data, 32'h87654321 + 32'(i)); end
      end
      bus_a.in1_valid = 1'b0;
      #1;
      tests++; if (bus_a.in0_ready !== 1'b1) begin errors++; $display("FAIL lock_release_ready0 got %b want 1", bus_a.in0_ready); end
      tick();
      tests++; if (bus_a.out_src !== 1'b0) begin errors++; $display("FAIL lock_release_src got %b want 0", bus_a.out_src); end
      idle_a();
   endtask

   task automatic test_stall();
      reset_a();
      bus_a.in0_valid = 1'b1; bus_a.in0_data = 32'h0000D000;
      tick();
      bus_a.in0_data  = 32'h0000D001;
      bus_a.in1_valid = 1'b1; bus_a.in1_data = 32'h0000D002;
      bus_a.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests++; if (bus_a.in0_ready !== 1'b0) begin errors++; $display("FAIL stall_ready0[%0d] got %b want 0", i, bus_a.in0_ready); end
         tests++; if (bus_a.in1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready1[%0d] got %b want 0", i, bus_a.in1_ready); end
         tick();
         tests++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus_a.out_valid); end
         tests++; if (bus_a.out_data !== 32'h0000D000) begin errors++; $display("FAIL stall_data[%0d] got %h want 0000d000", i, bus_a.out_data); end
         tests++; if (bus_a.grant_cnt0 !== 16'd1 || bus_a.grant_cnt1 !== 16'd0) begin errors++; $display("FAIL stall_cnt[%0d] got %0d/%0d want 1/0", i, bus_a.grant_cnt0, bus_a.grant_cnt1); end
      end
      bus_a.out_ready = 1'b1;
      #1;
      tests++; if (bus_a.in1_ready !== 1'b1 || bus_a.in0_ready !== 1'b0) begin errors++; $display("FAIL stall_release_ready got %b%b want 10", bus_a.in1_ready, bus_a.in0_ready); end
      tick();
      tests++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid got %b want 1", bus_a.out_valid); end
      tests++; if (bus_a.out_data !== 32'h0000D002) begin errors++; $display("FAIL stall_release_data got %h want 0000d002", bus_a.out_data); end
      tests++; if (bus_a.out_src !== 1'b1) begin errors++; $display("FAIL stall_release_src got %b want 1", bus_a.out_src); end
      idle_a();
   endtask

   task automatic test_reset_mid_burst();
      reset_a();
      bus_a.in0_valid = 1'b1; bus_a.in0_data = 32'h11110000; bus_a.in0_lock = 1'b1;
      tick();
      bus_a.in0_data  = 32'h11110001;
      bus_a.in1_valid = 1'b1; bus_a.in1_data = 32'h22220000;
      #1;
      tests++; if (bus_a.in1_ready !== 1'b0) begin errors++; $display("FAIL burst_lock_blocks1 got %b want 0", bus_a.in1_ready); end
      tick();
      rst_a = 1'b1;
      #1;
      tests++; if (bus_a.in0_ready !== 1'b0 || bus_a.in1_ready !== 1'b0) begin errors++; $display("FAIL burst_reset_ready got %b%b want 00", bus_a.in0_ready, bus_a.in1_ready); end
      tick();
      rst_a = 1'b0;
      bus_a.in0_lock = 1'b0;
      tests++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL burst_reset_valid got %b want 0", bus_a.out_valid); end
      tests++; if (bus_a.grant_cnt0 !== 16'd0 || bus_a.grant_cnt1 !== 16'd0) begin errors++; $display("FAIL burst_reset_cnt got %0d/%0d want 0/0", bus_a.grant_cnt0, bus_a.grant_cnt1); end
      #1;
      tests++; if (bus_a.in0_ready !== 1'b1 || bus_a.in1_ready !== 1'b0) begin errors++; $display("FAIL burst_tie got %b%b want 10", bus_a.in0_ready, bus_a.in1_ready); end
      tick();
      tests++; if (bus_a.out_src !== 1'b0) begin errors++; $display("FAIL burst_tie_src got %b want 0", bus_a.out_src); end
      idle_a();
   endtask

   task automatic test_saturate();
      int exp;
      bus_b.in0_valid = 1'b0; bus_b.in0_data = '0; bus_b.in0_lock = 1'b0;
      bus_b.in1_valid = 1'b0; bus_b.in1_data = '0; bus_b.in1_lock = 1'b0;
      bus_b.out_ready = 1'b1;
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      bus_b.in0_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus_b.in0_data = 32'(i);
         tick();
         exp = (i + 1 > 15) ? 15 : i + 1;
         tests++; if (bus_b.grant_cnt0 !== 4'(exp)) begin errors++; $display("FAIL sat_cnt0[%0d] got %0d want %0d", i, bus_b.grant_cnt0, exp); end
      end
      tests++; if (bus_b.grant_cnt1 !== 4'd0) begin errors++; $display("FAIL sat_cnt1 got %0d want 0", bus_b.grant_cnt1); end
      bus_b.in0_valid = 1'b0;
   endtask

   task automatic test_random();
      bit          p0, p1, l0, l1, rs, ordy, can, e0, e1;
      logic [31:0] d0, d1;
      bit          m_valid, m_src;
      logic [31:0] m_data;
      int          mc0, mc1, owner, prio, cand, n;
      reset_a();
      p0 = 0; p1 = 0; l0 = 0; l1 = 0; d0 = '0; d1 = '0;
      m_valid = 0; m_src = 0; m_data = '0; mc0 = 0; mc1 = 0; owner = -1; prio = 0;
      for (int c = 0; c < 2000; c++) begin
         if (!p0 && $urandom_range(2) != 0) begin p0 = 1; d0 = $urandom; l0 = ($urandom_range(2) == 0); end
         if (!p1 && $urandom_range(2) != 0) begin p1 = 1; d1 = $urandom; l1 = ($urandom_range(2) == 0); end
         rs   = ($urandom_range(63) == 0);
         ordy = ($urandom_range(3) != 0);
         rst_a = rs;
         bus_a.in0_valid = p0; bus_a.in0_data = d0; bus_a.in0_lock = l0;
         bus_a.in1_valid = p1; bus_a.in1_data = d1; bus_a.in1_lock = l1;
         bus_a.out_ready = ordy;
         #1;
         can  = !m_valid || ordy;
         cand = -1;
         if (owner >= 0) begin
            if ((owner == 0 && p0) || (owner == 1 && p1)) cand = owner;
         end else if (p0 && p1) cand = prio;
         else if (p0) cand = 0;
         else if (p1) cand = 1;
         e0 = !rs && can && (cand == 0);
         e1 = !rs && can && (cand == 1);
         tests++; if (bus_a.in0_ready !== e0) begin errors++; $display("FAIL rnd_ready0[%0d] got %b want %b", c, bus_a.in0_ready, e0); end
         tests++; if (bus_a.in1_ready !== e1) begin errors++; $display("FAIL rnd_ready1[%0d] got %b want %b", c, bus_a.in1_ready, e1); end
         tick();
         if (rs) begin
            m_valid = 0; m_data = '0; m_src = 0; mc0 = 0; mc1 = 0; owner = -1; prio = 0;
         end else if (e0 || e1) begin
            n       = e0 ? 0 : 1;
            m_valid = 1;
            m_data  = (n == 1) ? d1 : d0;
            m_src   = (n == 1);
            if (n == 0 && mc0 < 65535) mc0++;
            if (n == 1 && mc1 < 65535) mc1++;
            prio  = 1 - n;
            owner = (((n == 1) ? l1 : l0) != 0) ? n : -1;
            if (n == 0) p0 = 0; else p1 = 0;
         end else if (m_valid && ordy) begin
            m_valid = 0;
         end
         tests++; if (bus_a.out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", c, bus_a.out_valid, m_valid); end
         tests++; if (bus_a.out_data !== m_data) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", c, bus_a.out_data, m_data); end
         tests++; if (bus_a.out_src !== m_src) begin errors++; $display("FAIL rnd_src[%0d] got %b want %b", c, bus_a.out_src, m_src); end
         tests++; if (bus_a.grant_cnt0 !== 16'(mc0) || bus_a.grant_cnt1 !== 16'(mc1)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", c, bus_a.grant_cnt0, bus_a.grant_cnt1, mc0, mc1); end
      end
      rst_a = 1'b0;
      idle_a();
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      idle_a();
      bus_b.in0_valid = 1'b0; bus_b.in0_data = '0; bus_b.in0_lock = 1'b0;
      bus_b.in1_valid = 1'b0; bus_b.in1_data = '0; bus_b.in1_lock = 1'b0;
      bus_b.out_ready = 1'b1;
      tick();
      test_reset();
      test_single();
      test_alternate();
      test_lock();
      test_stall();
      test_reset_mid_burst();
      test_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
